sdp_ram_init: RTL

SDP_RAM_INIT -- requirements
Module: sdp_ram_init

---
 rtl/sdp_ram_init.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sdp_ram_init.sv
// sdp_ram_init: simple dual-port RAM with byte-lane writes and self-clearing start-up.
// After reset, an INIT sweep writes zero to every word, one word per cycle.
// User reads and writes are accepted only after the sweep completes (init_done=1).
// The read path has one or two registered stages.
// On a same-address read-during-write, RDW_MODE selects whether the read returns the old word or the merged word.
module sdp_ram_init #(
  parameter int MEM_DEPTH    = 1024,
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  localparam int AW          = $clog2(MEM_DEPTH),
  localparam int NB          = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         ra,
  input  logic                  re,
  input  logic [AW-1:0]         wa,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  we,
  input  logic [NB-1:0]         be,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  init_done
);

  // Elaboration-time parameter checks.
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("sdp_ram_init: READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("sdp_ram_init: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (MEM_DEPTH < 4 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sdp_ram_init: MEM_DEPTH must be a power of two and at least 4");
  end

  // The clear counter is one bit wider than the address.
  // This lets it reach MEM_DEPTH, which marks the idle INIT cycle that follows the last clear write.
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] CNT_END = CW'(MEM_DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    clr_en;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NB-1:0]           wr_be;
  logic                    user_wr;

  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]   s1_data_q, s1_data_d;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  // State register and clear counter; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments.
    // Every flop then samples values from before the edge, whatever order the processes run in.
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: advance the clear counter through INIT, then park in READY.
  always_comb begin
    // NOTE: every signal driven in this block gets a default first.
    // A path that leaves a signal unassigned would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_END) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // FSM outputs: clear-write strobe during the sweep, init_done once READY.
  always_comb begin
    clr_en    = 1'b0;
    init_done = 1'b0;
    case (state_q)
      ST_INIT:  clr_en    = (cnt_q != CNT_END);
      ST_READY: init_done = 1'b1;
      default:  ;
    endcase
  end

  // Write-port mux: the clear sweep owns the port in INIT; user writes are accepted only in READY.
  always_comb begin
    user_wr = !reset && init_done && we;
    wr_en   = 1'b0;
    wr_addr = wa;
    wr_data = d;
    wr_be   = be;
    if (!reset) begin
      if (clr_en) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q[AW-1:0];
        wr_data = '0;
        wr_be   = '1;
      end else if (user_wr) begin
        wr_en   = 1'b1;
      end
    end
  end

  // Memory array with per-lane write enables.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately left out of reset, so it can map onto block RAM.
    // The INIT sweep gives it defined contents.
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // First read stage: fetch the word and, in RDW_MODE 1, overlay any lanes written at the same address in this cycle.
  always_comb begin
    rd_en   = !reset && init_done && re;
    rd_word = mem[ra];
    if (RDW_MODE == 1 && user_wr && wa == ra) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = d[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    s1_valid_d = rd_en;
    s1_data_d  = rd_en ? rd_word : s1_data_q;
  end

  // First read stage registers; reset flushes the pipeline and clears the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

    // Second read stage: forward stage-1 data only when it carries a read, so q holds otherwise.
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    // Second read stage registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign q       = s2_data_q;
    assign q_valid = s2_valid_q;
  end else begin : g_lat1
    assign q       = s1_data_q;
    assign q_valid = s1_valid_q;
  end

endmodule
